// File: rtl/count_pair_monitor.sv
// rtl/count_pair_monitor.sv - checks up/down counter pair for complement and legal stepping
// Counts 15->0 wraps of up_count and latches a sticky cause code on the first violation.
module count_pair_monitor #(
   parameter int WRAP_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        up_count,
   input  logic [3:0]        down_count,
   input  logic              clear,
   output logic              locked,
   output logic              err,
   output logic [1:0]        err_code,
   output logic              wrap_pulse,
   output logic [WRAP_W-1:0] wrap_count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SYNC  = 2'd1,
      S_TRACK = 2'd2,
      S_ERROR = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        prev_q, prev_d;
   logic              locked_q, locked_d;
   logic              err_q, err_d;
   logic [1:0]        err_code_q, err_code_d;
   logic              wrap_pulse_q, wrap_pulse_d;
   logic [WRAP_W-1:0] wrap_count_q, wrap_count_d;

   logic c_ok;
   logic s_ok;
   logic is_wrap;

   assign c_ok    = (down_count == ~up_count);
   assign s_ok    = (up_count == prev_q) || (up_count == prev_q + 4'd1);
   assign is_wrap = (prev_q == 4'hF) && (up_count == 4'h0);

   always_comb begin
      state_d      = state_q;
      prev_d       = prev_q;
      err_code_d   = err_code_q;
      wrap_pulse_d = 1'b0;
      wrap_count_d = wrap_count_q;

      if (clear) begin
         state_d      = S_IDLE;
         err_code_d   = 2'b00;
         wrap_count_d = '0;
      end else begin
         case (state_q)
            S_IDLE: state_d = S_SYNC;
            S_SYNC: begin
               if (c_ok) begin
                  prev_d  = up_count;
                  state_d = S_TRACK;
               end
            end
            S_TRACK: begin
               if (!c_ok || !s_ok) begin
                  state_d    = S_ERROR;
                  err_code_d = {~s_ok, ~c_ok};
               end else begin
                  prev_d = up_count;
                  if (is_wrap) begin
                     wrap_pulse_d = 1'b1;
                     // Saturate rather than roll over so the controller never sees a small count after many wraps.
                     if (wrap_count_q != '1) begin
                        wrap_count_d = wrap_count_q + 1'b1;
                     end
                  end
               end
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
         endcase
      end

      locked_d = (state_d == S_TRACK);
      err_d    = (state_d == S_ERROR);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         prev_q       <= 4'h0;
         locked_q     <= 1'b0;
         err_q        <= 1'b0;
         err_code_q   <= 2'b00;
         wrap_pulse_q <= 1'b0;
         wrap_count_q <= '0;
      end else begin
         state_q      <= state_d;
         prev_q       <= prev_d;
         locked_q     <= locked_d;
         err_q        <= err_d;
         err_code_q   <= err_code_d;
         wrap_pulse_q <= wrap_pulse_d;
         wrap_count_q <= wrap_count_d;
      end
   end

   assign locked     = locked_q;
   assign err        = err_q;
   assign err_code   = err_code_q;
   assign wrap_pulse = wrap_pulse_q;
   assign wrap_count = wrap_count_q;

endmodule

// File: tb/tb_count_pair_monitor.sv
// tb/tb_count_pair_monitor.sv - randomized and directed bench for count_pair_monitor
// Outputs are compared each cycle against a behavioural model of the monitor rules.
module tb_count_pair_monitor;

   localparam int WRAP_W = 8;
   localparam int WRAP_MAX = (1 << WRAP_W) - 1;

   logic              clk;
   logic              reset;
   logic [3:0]        up_count;
   logic [3:0]        down_count;
   logic              clear;
   logic              locked;
   logic              err;
   logic [1:0]        err_code;
   logic              wrap_pulse;
   logic [WRAP_W-1:0] wrap_count;

   int n_checks;
   int n_fail;

   // behavioural model
   bit       m_armed;
   bit       m_synced;
   bit       m_failed;
   int       m_prev;
   int       m_code;
   int       m_wraps;
   bit       m_pulse;

   count_pair_monitor #(.WRAP_W(WRAP_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .up_count   (up_count),
      .down_count (down_count),
      .clear      (clear),
      .locked     (locked),
      .err        (err),
      .err_code   (err_code),
      .wrap_pulse (wrap_pulse),
      .wrap_count (wrap_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [WRAP_W+4:0] act_vec();
      return {locked, err, err_code, wrap_pulse, wrap_count};
   endfunction

   function automatic logic [WRAP_W+4:0] exp_vec();
      logic [WRAP_W-1:0] w;
      logic [1:0]        c;
      w = WRAP_W'(m_wraps);
      c = 2'(m_code);
      return {(m_synced && !m_failed), m_failed, c, m_pulse, w};
   endfunction

   task automatic model_reset();
      m_armed = 0; m_synced = 0; m_failed = 0;
      m_prev = 0; m_code = 0; m_wraps = 0; m_pulse = 0;
   endtask

   task automatic model_edge(input int u, input int d, input bit c);
      bit cf, sf;
      m_pulse = 0;
      if (c) begin
         m_armed = 0; m_synced = 0; m_failed = 0; m_code = 0; m_wraps = 0;
      end else if (m_failed) begin
         // sticky: nothing changes
      end else if (!m_armed) begin
         m_armed = 1;
      end else if (!m_synced) begin
         if (u + d == 15) begin
            m_synced = 1;
            m_prev = u;
         end
      end else begin
         cf = (u + d != 15);
         sf = (((u - m_prev + 16) % 16) > 1);
         if (cf || sf) begin
            m_failed = 1;
            m_code = (sf ? 2 : 0) + (cf ? 1 : 0);
         end else begin
            if (m_prev == 15 && u == 0) begin
               m_pulse = 1;
               if (m_wraps < WRAP_MAX) m_wraps++;
            end
            m_prev = u;
         end
      end
   endtask

   // drive one sample, let the edge take it, then settle 1 time unit past the edge
   task automatic cyc(input int u, input int d, input bit c);
      up_count = 4'(u);
      down_count = 4'(d);
      clear = c;
      @(posedge clk);
      model_edge(u, d, c);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      up_count = 4'd0; down_count = 4'd15; clear = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #3 reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL reset_state actual=%h expected=%h", act_vec(), exp_vec());
      end
      for (int i = 0; i < 3; i++) begin
         cyc(0, 15, 0);
         n_checks++;
         if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_bringup cyc=%0d actual=%h expected=%h", i, act_vec(), exp_vec());
         end
         if (i == 1) begin
            n_checks++;
            if (locked !== 1'b1) begin
               n_fail++;
               $display("FAIL locked_at_edge2 actual=%b expected=1", locked);
            end
         end
      end
      // async reset mid-TRACK at a non-edge time
      for (int u = 1; u <= 15; u++) cyc(u, 15 - u, 0);
      cyc(0, 15, 0);
      #2 reset = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if ({locked, err, wrap_pulse, wrap_count} !== '0) begin
         n_fail++;
         $display("FAIL async_reset actual=%h expected=0", act_vec());
      end
      #2 reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cyc(0, 15, 0);
         n_checks++;
         if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_release cyc=%0d actual=%h expected=%h", i, act_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_wraps();
      int pulses;
      pulses = 0;
      cyc(0, 15, 1);
      cyc(0, 15, 0);
      cyc(0, 15, 0);
      for (int r = 0; r < 3; r++) begin
         for (int k = 1; k <= 16; k++) begin
            cyc(k % 16, 15 - (k % 16), 0);
            pulses += int'(wrap_pulse);
            n_checks++;
            if (act_vec() !== exp_vec()) begin
               n_fail++;
               $display("FAIL wrap_run r=%0d k=%0d actual=%h expected=%h", r, k, act_vec(), exp_vec());
            end
         end
      end
      n_checks++;
      if (pulses != 3 || wrap_count !== 8'd3 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_total pulses=%0d count=%0d err=%b expected 3 3 0", pulses, wrap_count, err);
      end
   endtask

   task automatic test_complement_fault();
      for (int u = 1; u <= 3; u++) cyc(u, 15 - u, 0);
      cyc(3, 5, 0);
      n_checks++;
      if (err !== 1'b1 || err_code !== 2'b01 || locked !== 1'b0 || wrap_count !== 8'd3) begin
         n_fail++;
         $display("FAIL complement_fault actual=%h expected err=1 code=01 locked=0 wraps=3", act_vec());
      end
      n_checks++;
      if (act_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL complement_model actual=%h expected=%h", act_vec(), exp_vec());
      end
   endtask

   task automatic test_step_fault();
      cyc(4, 11, 1);
      cyc(4, 11, 0);
      cyc(4, 11, 0);
      cyc(6, 9, 0);
      n_checks++;
      if (err !== 1'b1 || err_code !== 2'b10) begin
         n_fail++;
         $display("FAIL step_fault actual err=%b code=%b expected err=1 code=10", err, err_code);
      end
      cyc(7, 0, 0);
      n_checks++;
      if (err_code !== 2'b10 || act_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL step_sticky actual=%h expected=%h", act_vec(), exp_vec());
      end
   endtask

   task automatic test_hold_and_sync();
      cyc(2, 2, 1);
      for (int i = 0; i < 5; i++) begin
         cyc(2, 2, 0);
         n_checks++;
         if (locked !== 1'b0 || err !== 1'b0 || act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL sync_invalid i=%0d actual=%h expected=%h", i, act_vec(), exp_vec());
         end
      end
      for (int i = 0; i < 5; i++) cyc(7, 8, 0);
      cyc(8, 7, 0);
      n_checks++;
      if (locked !== 1'b1 || err !== 1'b0 || act_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL hold_resume actual=%h expected=%h", act_vec(), exp_vec());
      end
   endtask

   task automatic test_saturation();
      int errs_seen;
      errs_seen = 0;
      cyc(0, 15, 1);
      cyc(0, 15, 0);
      cyc(0, 15, 0);
      for (int r = 0; r < 300; r++) begin
         for (int k = 1; k <= 16; k++) begin
            cyc(k % 16, 15 - (k % 16), 0);
            if (act_vec() !== exp_vec()) errs_seen++;
         end
      end
      n_checks++;
      if (errs_seen != 0) begin
         n_fail++;
         $display("FAIL saturation_run actual=%0d cycles off model expected=0", errs_seen);
      end
      n_checks++;
      if (wrap_count !== 8'd255 || wrap_pulse !== 1'b1) begin
         n_fail++;
         $display("FAIL saturation_end actual count=%0d pulse=%b expected 255 1", wrap_count, wrap_pulse);
      end
      cyc(1, 3, 1);
      n_checks++;
      if ({locked, err, err_code, wrap_count} !== '0 || act_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL clear_over_fault actual=%h expected=%h", act_vec(), exp_vec());
      end
   endtask

   task automatic test_random();
      int u, d, r, bad;
      bit c;
      bad = 0;
      u = 0;
      cyc(0, 15, 1);
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 99);
         c = 0;
         if (r < 60)      u = (u + 1) % 16;
         else if (r < 85) u = u;
         else if (r < 90) u = $urandom_range(0, 15);
         else if (r < 97) u = u;
         else             c = 1;
         d = (r >= 90 && r < 97) ? int'($urandom_range(0, 15)) : 15 - u;
         cyc(u, d, c);
         n_checks++;
         if (act_vec() !== exp_vec()) begin
            n_fail++;
            bad++;
            if (bad < 10)
               $display("FAIL random i=%0d up=%0d down=%0d clr=%0d actual=%h expected=%h", i, u, d, c, act_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      reset = 1'b0;
      clear = 1'b0;
      up_count = 4'd0;
      down_count = 4'd15;
      test_reset();
      test_wraps();
      test_complement_fault();
      test_step_fault();
      test_hold_and_sync();
      test_saturation();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/count_pair_monitor.md
# count_pair_monitor

Checks, cycle by cycle, the pair of 4-bit counts produced by the up/down counter stage: up_count and down_count. It confirms that the two counts stay complementary and that up_count advances legally. It also counts up_count wrap-arounds and latches a sticky error with a cause code on the first violation. It sits directly downstream of the counter, on the same clock, and feeds status to the system controller.

## Interface
- WRAP_W, 8, width of wrap_count; saturates at 2^WRAP_W-1
- clk  input  1  rising-edge clock, shared with the counter
- reset  input  1  asynchronous, active-low; 0 forces all state and outputs to reset values immediately
- up_count  input  4  counter up output, sampled on rising clk
- down_count  input  4  counter down output, sampled on rising clk
- clear  input  1  synchronous re-arm; 1 at an edge sends FSM to IDLE, zeroes wrap_count, err, err_code
- locked  output  1  1 while FSM is in TRACK
- err  output  1  sticky violation flag; 1 only in ERROR
- err_code  output  2  01 = complement fail, 10 = step fail, 11 = both, 00 = none
- wrap_pulse  output  1  one-cycle pulse per detected 15->0 wrap of up_count
- wrap_count  output  WRAP_W  number of wraps since reset/clear, saturating

## Operation
- Decided: one clock; reset is asynchronous and active-low, port names clk and reset.
- Complement check (C): pass when down_count == ~up_count (4-bit), i.e. up+down == 15.
- Step check (S): pass when up_count == prev or up_count == prev+1 mod 16. prev is the up_count registered at the previous edge. A hold (same value) is legal.
- FSM states: IDLE, SYNC, TRACK, ERROR. Reset value is IDLE.
- IDLE: go to SYNC at the next edge unconditionally.
- SYNC: if C passes, load prev <= up_count and go to TRACK. If C fails, stay in SYNC with no error.
- TRACK: evaluate C and S on every edge.
  - Any fail: go to ERROR and load err_code = {S fail, C fail}. wrap_count is not updated on that edge.
  - Both pass: prev <= up_count.
  - Wrap: prev == 15 and up_count == 0. Set wrap_pulse = 1 for that cycle and increment wrap_count, saturating at all-ones.
- ERROR: hold err = 1, err_code, and wrap_count. Leave only via clear or reset.
- clear has priority over every transition in every state.
- Reset value of every output: locked 0, err 0, err_code 00, wrap_pulse 0, wrap_count 0. Internal prev resets to 0.
- Counter held in its own reset (up = 0, down = 15 held constant) is a legal hold: no error, no wrap.

## Timing
- All outputs are registered. A sample taken at edge N is reflected in the outputs from just after edge N.
- After reset deassertion with a valid pair:
  - edge 1: IDLE->SYNC
  - edge 2: SYNC->TRACK, locked = 1
- Violation latency: 1 edge from the offending sample to err = 1 and locked = 0.
- wrap_pulse is high for exactly one cycle, following the edge that sampled up_count = 0 after 15. wrap_count updates on the same edge.
- reset asserted mid-TRACK or mid-ERROR: outputs go to reset values asynchronously, without waiting for an edge.
- clear and a violation on the same edge: clear wins, and the state goes to IDLE with err = 0.
- Saturation: at wrap_count = 2^WRAP_W-1 a further wrap still pulses wrap_pulse, but the count stays at max.

## Test plan
- Reset low mid-TRACK at a non-edge time -> locked, err, wrap_pulse, wrap_count go to 0 immediately. After release, locked = 1 at the 2nd edge.
- Drive up = 0..15 with down = 15-up, for 3 full cycles -> no err; wrap_pulse goes high 3 times, one cycle each; wrap_count = 3.
- In TRACK, drive up = 3, down = 5 -> next edge err = 1, err_code = 01, locked = 0; wrap_count frozen at its prior value.
- In TRACK, up jumps 4 -> 6 with down = 9 -> err_code = 10. Then apply up = 7, down = 0 -> err_code stays 10 (sticky).
- Hold up = 7, down = 8 for 5 cycles, then resume 8/7 -> no err, locked stays 1. In SYNC, apply an invalid pair 2/2 for 4 cycles -> stays in SYNC, err = 0.
- WRAP_W = 8: run 300 wraps -> wrap_count = 255 with wrap_pulse still pulsing. Assert clear together with an injected complement fault -> IDLE, err = 0, wrap_count = 0.
